// File: rtl/mshr_refill_if.sv
// mshr_refill_if: cache-controller and memory handshake bundle for the refill engine
interface mshr_refill_if #(
    parameter int ADR_WIDTH     = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DATAMEM_WIDTH = 128
);
    logic                     req_cc2mshr;
    logic [ADR_WIDTH-1:0]     adr_cc2mshr;
    logic                     busy_mshr2cc;
    logic                     crit_vld_mshr2cc;
    logic [DATA_WIDTH-1:0]    crit_dat_mshr2cc;
    logic                     ack_mshr2cc;
    logic [DATAMEM_WIDTH-1:0] dat_mshr2cc;
    logic                     req_mshr2mem;
    logic [ADR_WIDTH-1:0]     adr_mshr2mem;
    logic                     ack_mem2mshr;
    logic [DATA_WIDTH-1:0]    dat_mem2mshr;
    modport master (
        output req_cc2mshr, adr_cc2mshr, ack_mem2mshr, dat_mem2mshr,
        input  busy_mshr2cc, crit_vld_mshr2cc, crit_dat_mshr2cc, ack_mshr2cc, dat_mshr2cc,
               req_mshr2mem, adr_mshr2mem
    );
    modport slave (
        input  req_cc2mshr, adr_cc2mshr, ack_mem2mshr, dat_mem2mshr,
        output busy_mshr2cc, crit_vld_mshr2cc, crit_dat_mshr2cc, ack_mshr2cc, dat_mshr2cc,
               req_mshr2mem, adr_mshr2mem
    );
endinterface

// File: rtl/mshr_refill.sv
// mshr_refill: single-entry miss refill engine with early critical-word forwarding.
// Define MSHR_CRIT_WORD_FIRST_EN to fetch critical word first (wrapping); default fetches in order.
module mshr_refill #(
    parameter int ADR_WIDTH     = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int WORD_OFFSET   = 2,
    parameter int DATAMEM_WIDTH = 128
) (
    input logic        clk,
    input logic        rst,
    mshr_refill_if.slave bus
);
    localparam int BO = $clog2(DATA_WIDTH / 8);
    localparam int TW = ADR_WIDTH - WORD_OFFSET - BO;
    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
    state_t                   state;
    logic [TW-1:0]            tag;
    logic [WORD_OFFSET-1:0]   widx, crit_idx, cnt, start_idx;
    logic [DATAMEM_WIDTH-1:0] line;
`ifdef MSHR_CRIT_WORD_FIRST_EN
    assign start_idx = bus.adr_cc2mshr[BO +: WORD_OFFSET];
`else
    assign start_idx = '0;
`endif
    assign bus.adr_mshr2mem = {tag, widx, {BO{1'b0}}};
    assign bus.dat_mshr2cc  = line;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= IDLE;
            tag                  <= '0;
            widx                 <= '0;
            crit_idx             <= '0;
            cnt                  <= '0;
            line                 <= '0;
            bus.busy_mshr2cc     <= 1'b0;
            bus.crit_vld_mshr2cc <= 1'b0;
            bus.crit_dat_mshr2cc <= '0;
            bus.ack_mshr2cc      <= 1'b0;
            bus.req_mshr2mem     <= 1'b0;
        end else begin
            bus.crit_vld_mshr2cc <= 1'b0;
            bus.ack_mshr2cc      <= 1'b0;
            case (state)
                IDLE: if (bus.req_cc2mshr) begin
                    tag              <= bus.adr_cc2mshr[ADR_WIDTH-1 -: TW];
                    crit_idx         <= bus.adr_cc2mshr[BO +: WORD_OFFSET];
                    widx             <= start_idx;
                    cnt              <= '0;
                    bus.req_mshr2mem <= 1'b1;
                    bus.busy_mshr2cc <= 1'b1;
                    state            <= FETCH;
                end
                FETCH: if (bus.ack_mem2mshr) begin
                    line[widx*DATA_WIDTH +: DATA_WIDTH] <= bus.dat_mem2mshr;
                    if (widx == crit_idx) begin
                        bus.crit_dat_mshr2cc <= bus.dat_mem2mshr;
                        bus.crit_vld_mshr2cc <= 1'b1;
                    end
                    widx <= widx + 1'b1;
                    cnt  <= cnt + 1'b1;
                    // last word of the line: close the burst and raise completion
                    if (cnt == '1) begin
                        bus.req_mshr2mem <= 1'b0;
                        bus.ack_mshr2cc  <= 1'b1;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    bus.busy_mshr2cc <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mshr_refill.sv
// tb_mshr_refill: scoreboard bench for mshr_refill; follows MSHR_CRIT_WORD_FIRST_EN like the RTL
module tb_mshr_refill;
    localparam bit CWF =
`ifdef MSHR_CRIT_WORD_FIRST_EN
        1'b1;
`else
        1'b0;
`endif
    typedef logic [3:0][31:0] words_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    mshr_refill_if bus ();
    mshr_refill dut (.clk(clk), .rst(rst), .bus(bus));
    int n_chk = 0;
    int n_fail = 0;
    logic [127:0] line_q[$];
    logic [31:0]  crit_q[$];
    logic [127:0] last_line;
    logic [31:0]  last_crit;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] st(input logic [31:0] a);
        return a[3:2] & {2{CWF}};
    endfunction
    function automatic logic [31:0] eadr(input logic [31:0] a, input int k);
        return {a[31:4], 2'(int'(st(a)) + k), 2'b00};
    endfunction
    function automatic logic [127:0] eline(input logic [31:0] a, input words_t d);
        logic [127:0] l;
        logic [1:0]   s;
        l = '0;
        for (int k = 0; k < 4; k++) begin
            s = 2'(int'(st(a)) + k);
            l[s*32 +: 32] = d[k];
        end
        return l;
    endfunction
    function automatic logic [31:0] ecrit(input logic [31:0] a, input words_t d);
        logic [1:0] k;
        k = a[3:2] - st(a);
        return d[k];
    endfunction

    // scoreboard monitor: pops on every completion / critical-word pulse
    always @(negedge clk) if (rst) begin
        if (bus.ack_mshr2cc) begin
            if (line_q.size() == 0) chk("spurious_line_ack", bus.ack_mshr2cc, 0);
            else chk("line_data", bus.dat_mshr2cc, line_q.pop_front());
        end
        if (bus.crit_vld_mshr2cc) begin
            if (crit_q.size() == 0) chk("spurious_crit_vld", bus.crit_vld_mshr2cc, 0);
            else chk("crit_data", bus.crit_dat_mshr2cc, crit_q.pop_front());
        end
    end

    task automatic check_zero(input string nm);
        chk({nm, "_busy"}, bus.busy_mshr2cc, 0);
        chk({nm, "_crit_vld"}, bus.crit_vld_mshr2cc, 0);
        chk({nm, "_crit_dat"}, bus.crit_dat_mshr2cc, 0);
        chk({nm, "_ack"}, bus.ack_mshr2cc, 0);
        chk({nm, "_dat"}, bus.dat_mshr2cc, 0);
        chk({nm, "_req_mem"}, bus.req_mshr2mem, 0);
        chk({nm, "_adr_mem"}, bus.adr_mshr2mem, 0);
    endtask

    task automatic accept(input logic [31:0] a, input words_t d, input bit hold);
        bus.req_cc2mshr = 1'b1;
        bus.adr_cc2mshr = a;
        @(posedge clk); #1;
        if (!hold) bus.req_cc2mshr = 1'b0;
        chk("accept_busy", bus.busy_mshr2cc, 1);
        chk("accept_req_mem", bus.req_mshr2mem, 1);
        chk("accept_adr", bus.adr_mshr2mem, eadr(a, 0));
        line_q.push_back(eline(a, d));
        crit_q.push_back(ecrit(a, d));
        last_line = eline(a, d);
        last_crit = ecrit(a, d);
    endtask

    task automatic serve(input logic [31:0] a, input words_t d, input int gap, input bit poke, input int n);
        for (int k = 0; k < n; k++) begin
            repeat (gap) begin
                chk("adr_stable", bus.adr_mshr2mem, eadr(a, k));
                @(posedge clk); #1;
            end
            chk("adr_seq", bus.adr_mshr2mem, eadr(a, k));
            chk("req_mem_high", bus.req_mshr2mem, 1);
            bus.ack_mem2mshr = 1'b1;
            bus.dat_mem2mshr = d[k];
            if (poke && k == 1) begin
                bus.req_cc2mshr = 1'b1;
                bus.adr_cc2mshr = 32'h1234_5678;
            end
            @(posedge clk); #1;
            bus.ack_mem2mshr = 1'b0;
            bus.dat_mem2mshr = $urandom();
            if (poke) bus.req_cc2mshr = 1'b0;
            chk("crit_vld_timing", bus.crit_vld_mshr2cc, 2'(int'(st(a)) + k) == a[3:2]);
            chk("line_ack_timing", bus.ack_mshr2cc, k == 3);
            chk("busy_in_burst", bus.busy_mshr2cc, 1);
        end
    endtask

    task automatic finish_idle();
        @(posedge clk); #1;
        chk("idle_ack", bus.ack_mshr2cc, 0);
        chk("idle_busy", bus.busy_mshr2cc, 0);
        chk("idle_req_mem", bus.req_mshr2mem, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        words_t d;
        bus.req_cc2mshr = 1'b0;
        bus.adr_cc2mshr = '0;
        bus.ack_mem2mshr = 1'b0;
        bus.dat_mem2mshr = '0;
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        // gapped acks, hand-computed start address and line
        a = 32'hFF07BD08;
        d = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        accept(a, d, 0);
        chk("t1_first_adr", bus.adr_mshr2mem, CWF ? 32'hFF07BD08 : 32'hFF07BD00);
        serve(a, d, 1, 0, 4);
        chk("t1_line", bus.dat_mshr2cc, CWF ? 128'h22222222_11111111_44444444_33333333
                                            : 128'h44444444_33333333_22222222_11111111);
        finish_idle();
        // wrap at crit_idx=3 with back-to-back acks
        a = 32'hA5552D0C;
        d = {32'hA0000004, 32'hA0000003, 32'hA0000002, 32'hA0000001};
        accept(a, d, 0);
        chk("t2_first_adr", bus.adr_mshr2mem, CWF ? 32'hA5552D0C : 32'hA5552D00);
        serve(a, d, 0, 0, 4);
        finish_idle();
        // new request during FETCH must be ignored
        a = 32'h00C0FFE4;
        d = {32'hCAFE0004, 32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001};
        accept(a, d, 0);
        serve(a, d, 2, 1, 4);
        finish_idle();
        // stray memory acks while idle
        bus.ack_mem2mshr = 1'b1;
        bus.dat_mem2mshr = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1;
        bus.ack_mem2mshr = 1'b0;
        chk("stray_line", bus.dat_mshr2cc, last_line);
        chk("stray_crit_dat", bus.crit_dat_mshr2cc, last_crit);
        chk("stray_crit_vld", bus.crit_vld_mshr2cc, 0);
        chk("stray_busy", bus.busy_mshr2cc, 0);
        // request held through DONE re-fetches on the first IDLE cycle
        a = 32'h30000008;
        d = {32'h55550004, 32'h55550003, 32'h55550002, 32'h55550001};
        accept(a, d, 1);
        serve(a, d, 0, 0, 4);
        @(posedge clk); #1;
        chk("held_idle_busy", bus.busy_mshr2cc, 0);
        d = {32'h66660004, 32'h66660003, 32'h66660002, 32'h66660001};
        accept(a, d, 0);
        serve(a, d, 1, 0, 4);
        finish_idle();
        // abort mid-burst with reset
        a = 32'h0000100C;
        d = {32'h77770004, 32'h77770003, 32'h77770002, 32'h77770001};
        accept(a, d, 0);
        serve(a, d, 0, 0, 2);
        rst = 1'b0;
        #1;
        check_zero("abort");
        line_q.delete();
        crit_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        a = 32'h0BADF004;
        d = {32'h88880004, 32'h88880003, 32'h88880002, 32'h88880001};
        accept(a, d, 0);
        serve(a, d, 0, 0, 4);
        chk("post_abort_line", bus.dat_mshr2cc, CWF ? 128'h88880003_88880002_88880001_88880004
                                                    : 128'h88880004_88880003_88880002_88880001);
        finish_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("sb_line_drained", line_q.size(), 0);
        chk("sb_crit_drained", crit_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
